// File: rtl/sc_mem_pkg.sv
// Shared address-map constants for the single-cycle CPU data side.
// The CPU-side test software uses the same offsets, bit indices and reset values.
package sc_mem_pkg;

  localparam logic [31:0] IO_BASE = 32'h8000_0000;

  localparam logic [4:0] OFF_GPIO_OUT = 5'h00;
  localparam logic [4:0] OFF_GPIO_IN  = 5'h04;
  localparam logic [4:0] OFF_TCOUNT   = 5'h08;
  localparam logic [4:0] OFF_TCMP     = 5'h0C;
  localparam logic [4:0] OFF_CTRL     = 5'h10;
  localparam logic [4:0] OFF_STATUS   = 5'h14;

  localparam int CTRL_TEN     = 0;
  localparam int CTRL_IEN     = 1;
  localparam int STATUS_MATCH = 0;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Word index of each I/O register; the two spare slots read as zero.
  typedef enum logic [2:0] {
    REG_GPIO_OUT = OFF_GPIO_OUT[4:2],
    REG_GPIO_IN  = OFF_GPIO_IN[4:2],
    REG_TCOUNT   = OFF_TCOUNT[4:2],
    REG_TCMP     = OFF_TCMP[4:2],
    REG_CTRL     = OFF_CTRL[4:2],
    REG_STATUS   = OFF_STATUS[4:2],
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } io_reg_e;

  function automatic io_reg_e io_reg(input logic [2:0] sel);
    return io_reg_e'(sel);
  endfunction

endpackage

// File: rtl/sc_timer.sv
// Free-running 32-bit timer with compare, sticky match flag and registered irq.
// Only instantiated when SC_DMEM_TIMER_EN is defined.
module sc_timer
  import sc_mem_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic        wr_ctrl,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [1:0]  ctrl,
  output logic        status,
  output logic        irq
);

  logic match;

  assign match = ctrl[CTRL_TEN] && (count == cmp);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count  <= '0;
      cmp    <= TCMP_RST;
      ctrl   <= '0;
      status <= 1'b0;
      irq    <= 1'b0;
    end else begin
      // A CPU store to TCOUNT takes priority over the increment.
      if (wr_count) begin
        count <= wdata;
      end else if (ctrl[CTRL_TEN]) begin
        count <= count + 32'd1;
      end

      if (wr_cmp) begin
        cmp <= wdata;
      end

      if (wr_ctrl) begin
        ctrl <= wdata[1:0];
      end

      // Set beats write-1-to-clear so a match is never lost.
      if (match) begin
        status <= 1'b1;
      end else if (wr_status && wdata[STATUS_MATCH]) begin
        status <= 1'b0;
      end

      irq <= status & ctrl[CTRL_IEN];
    end
  end

endmodule

// File: rtl/sc_dmem_io.sv
// Data-side responder: word RAM below IO_BASE, GPIO and optional timer above it.
// Define SC_DMEM_TIMER_EN to build the timer, TCMP, CTRL, STATUS and irq.
module sc_dmem_io
  import sc_mem_pkg::*;
#(
  parameter int AW     = 6,
  parameter int GPIO_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  logic              io_sel;
  logic [AW-1:0]     ram_idx;
  io_reg_e           reg_sel;
  logic [31:0]       ram [2**AW];
  logic [GPIO_W-1:0] gpio_sync1;
  logic [GPIO_W-1:0] gpio_sync2;
  logic [31:0]       t_count;
  logic [31:0]       t_cmp;
  logic [1:0]        t_ctrl;
  logic              t_status;
  logic              unused_addr;

  // Upper RAM address bits alias; byte-lane bits are ignored everywhere.
  assign io_sel      = (addr[31] == IO_BASE[31]);
  assign ram_idx     = addr[AW+1:2];
  assign reg_sel     = io_reg(addr[4:2]);
  assign unused_addr = ^{addr[30:AW+2], addr[1:0]};

  // RAM is not reset; an edge that lands during reset drops the store.
  always_ff @(posedge clk) begin
    if (we && !io_sel && !clr) begin
      ram[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (we && io_sel && (reg_sel == REG_GPIO_OUT)) begin
        gpio_out <= wdata[GPIO_W-1:0];
      end
    end
  end

`ifdef SC_DMEM_TIMER_EN
  logic io_we;

  assign io_we = we & io_sel;

  sc_timer u_timer (
    .clk       (clk),
    .clr       (clr),
    .wr_count  (io_we && (reg_sel == REG_TCOUNT)),
    .wr_cmp    (io_we && (reg_sel == REG_TCMP)),
    .wr_ctrl   (io_we && (reg_sel == REG_CTRL)),
    .wr_status (io_we && (reg_sel == REG_STATUS)),
    .wdata     (wdata),
    .count     (t_count),
    .cmp       (t_cmp),
    .ctrl      (t_ctrl),
    .status    (t_status),
    .irq       (irq)
  );
`else
  assign t_count  = '0;
  assign t_cmp    = '0;
  assign t_ctrl   = '0;
  assign t_status = 1'b0;
  assign irq      = 1'b0;
`endif

  // Loads see pre-edge state, so a same-cycle store returns the old value.
  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = ram[ram_idx];
    end else begin
      case (reg_sel)
        REG_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_out;
        REG_GPIO_IN:  rdata[GPIO_W-1:0] = gpio_sync2;
        REG_TCOUNT:   rdata = t_count;
        REG_TCMP:     rdata = t_cmp;
        REG_CTRL:     rdata[1:0] = t_ctrl;
        REG_STATUS:   rdata[STATUS_MATCH] = t_status;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/sc_dmem_io.md
Name: sc_dmem_io

Overview:
- Data-side responder for the single-cycle CPU. Consumes the CPU's data-memory request (ALU address, store data, write enable) and returns read data in the same cycle.
- Decodes the address into a word-addressed RAM and a small memory-mapped I/O block: GPIO out/in, a 32-bit timer with compare, control and status registers, and an interrupt line.
- Sits between the CPU core and the board top level.

Parameters:
- AW, 6, RAM word-address width; depth is 2**AW words.
- GPIO_W, 16, width of the GPIO input and output ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous active-high reset.
- addr  in  32  byte address from the CPU ALU output.
- wdata  in  32  store data from the CPU.
- we  in  1  store enable from the CPU (wmen).
- rdata  out  32  load data to the CPU (dmem); combinational.
- gpio_in  in  GPIO_W  external inputs, asynchronous to clk.
- gpio_out  out  GPIO_W  registered external outputs.
- irq  out  1  timer interrupt request; registered.

Behaviour:
- Address decode:
  - addr[31]==0 selects RAM at word index addr[AW+1:2]. Upper address bits are ignored, so RAM aliases.
  - addr[31]==1 selects I/O, decoded on addr[4:2].
  - addr[1:0] is ignored everywhere; no misalignment fault.
- I/O map (offsets from 0x8000_0000):
  - 0x00 GPIO_OUT: RW.
  - 0x04 GPIO_IN: RO, 2-flop synchronised, zero-extended.
  - 0x08 TCOUNT: RW.
  - 0x0C TCMP: RW.
  - 0x10 CTRL: bit0 timer enable, bit1 irq enable; RW, other bits read 0.
  - 0x14 STATUS: bit0 match flag, write-1-to-clear.
  - Offsets 0x18 and 0x1C read 0; writes to them are ignored.
- Read path: rdata is purely combinational from addr and current state, so a load completes in the same cycle.
  - A load from an address written in the same cycle returns the old value.
- Write path: when we=1, the selected RAM word or register updates at the rising clk edge. Writes to RO registers are ignored.
- Timer:
  - When CTRL.bit0=1, TCOUNT increments by 1 each cycle and wraps 0xFFFF_FFFF -> 0.
  - A CPU write to TCOUNT in the same cycle overrides the increment.
  - Match: when TCOUNT==TCMP and CTRL.bit0=1, STATUS.bit0 sets at the next edge.
  - If a match and a W1C of STATUS.bit0 occur in the same cycle, set wins.
- irq: registered copy of (STATUS.bit0 & CTRL.bit1), so it lags the flag by one cycle.
- Reset:
  - The following clear asynchronously to 0: gpio_out, the GPIO sync flops, TCOUNT, CTRL, STATUS and irq.
  - TCMP resets to 0xFFFF_FFFF.
  - RAM contents are not reset.
  - Reset asserted mid-store aborts the store.

Optional Feature:
- SC_DMEM_TIMER_EN defined: the timer, TCMP, CTRL, STATUS and irq are implemented as specified above.
- SC_DMEM_TIMER_EN undefined:
  - Offsets 0x08 to 0x14 read 0 and ignore writes.
  - irq is tied to 0.
  - No timer flops are inferred.
  - RAM and GPIO behave identically in both builds.

Decomposition:
- Shared package sc_mem_pkg holds:
  - the IO_BASE constant (0x8000_0000);
  - register offset constants (GPIO_OUT, GPIO_IN, TCOUNT, TCMP, CTRL, STATUS);
  - CTRL/STATUS bit-index constants;
  - the TCMP reset value.
  The CPU-side test software uses the same constants.
- One sub-module: sc_timer, containing the count/compare/flag/irq logic. It takes register-write strobes and wdata, and exposes count, cmp, ctrl, status and irq. It is instantiated only under SC_DMEM_TIMER_EN.

Test Plan:
- RAM store/load: store 0xDEAD_BEEF at 0x0000_0010 -> next-cycle load of 0x10 returns 0xDEAD_BEEF. Load of 0x0000_0110 (alias, AW=6) also returns it; addr 0x13 returns it too.
- GPIO: store 0x0000_A5A5 to 0x8000_0000 -> gpio_out=0xA5A5 after the edge. Drive gpio_in=0x1234 -> load of 0x8000_0004 returns 0x0000_1234 within 2 cycles.
- Timer match:
  - Setup: TCOUNT=0, TCMP=5, CTRL=0x3.
  - STATUS.bit0 rises 6 edges after CTRL is written, and irq one cycle later.
  - W1C of STATUS -> irq drops the following cycle.
  - Simultaneous match and W1C -> flag stays 1.
- Wrap and override:
  - TCOUNT=0xFFFF_FFFF with enable on -> reads 0 next cycle.
  - A write to TCOUNT during counting -> the written value is held that edge, then increments.
- Reset: assert clr mid-count with we=1 -> all registers at reset values immediately, TCMP=0xFFFF_FFFF, irq=0, and the aborted store has no effect.
- Build without SC_DMEM_TIMER_EN: loads from 0x8000_0008 to 0x8000_0014 return 0 and irq stays 0 under the same stimulus as the timer-match scenario.
